// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
//   state_e       : controller FSM encoding (IDLE/RUN/DONE)
//   WIDTH_DEFAULT : default operand/result width
package serial_add_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_add_pkg

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder cell.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one fa_cell LSB-first over WIDTH cycles.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, cin, sub      : operands, carry-in, subtract request
//   out_valid, out_ready: result handshake (out_valid held until accepted)
//   sum, cout           : result and final carry-out, stable while out_valid
//   busy                : high while an operation is in RUN or DONE
// Build option: SERIAL_ADD_SUB_EN enables subtraction via sub (a + ~b + 1);
// without it, sub is ignored and the block is a pure adder.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             release_res;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             cell_s;
    logic             cell_co;

    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;
    assign last_bit    = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // Operand preparation: subtraction is a + ~b with the carry forced to 1.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign carry_load = cin;
`endif

    fa_cell u_fa_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)      state_nxt = RUN;
            RUN:     if (last_bit)    state_nxt = DONE;
            DONE:    if (release_res) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Datapath: capture on accept, one bit per RUN cycle, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            sum   <= {cell_s, sum[WIDTH-1:1]};
            carry <= cell_co;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                cout <= cell_co;
            end
        end
    end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with a result scoreboard.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_cmp;
    int n_err;
    logic [W:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {cout, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv, input logic sv);
        logic [W-1:0] bb;
        logic         cc;
        bb = bv;
        cc = cv;
`ifdef SERIAL_ADD_SUB_EN
        if (sv) begin
            bb = ~bv;
            cc = 1'b1;
        end
`else
        if (sv) cc = cv;
`endif
        return {1'b0, av} + {1'b0, bb} + (W+1)'(cc);
    endfunction

    // One full operation: handshake, latency/busy checks, scoreboard compare,
    // optional out_ready back-pressure, and return-to-IDLE checks.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic sv, input int hold, input bit inject, input bit early_ready);
        int k;
        logic [W:0] e;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        out_ready = early_ready;
        @(posedge clk);
        exp_q.push_back(model(av, bv, cv, sv));
        #1;
        in_valid = 1'b0;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid) break;
            check("busy_run", 32'(busy), 32'd1);
            check("in_ready_run", 32'(in_ready), 32'd0);
            if (inject && k == 2) begin
                a = ~av; b = ~bv; cin = ~cv; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            k++;
            if (k > 40) begin
                check("out_valid_timeout", 32'(k), 32'(W));
                break;
            end
        end
        in_valid = 1'b0;
        check("latency", 32'(k), 32'(W));
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
        check("busy_done", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(e[W-1:0]));
            check("hold_cout", 32'(cout), 32'(e[W]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("valid_released", 32'(out_valid), 32'd0);
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        // Back-pressure: result held for 5 cycles.
        do_op(8'hA5, 8'h6B, 1'b1, 1'b0, 5, 1'b0, 1'b0);
        // New request during RUN must be ignored.
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        // out_ready high during RUN is ignored; release on first DONE cycle.
        do_op(8'h80, 8'h80, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Abort in RUN cycle 3.
        @(negedge clk);
        a = 8'hFF; b = 8'h00; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_result", 32'(out_valid), 32'd0);
        do_op(8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Subtract requests (pure addition when the option is disabled).
        do_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'h01, 8'h02, 1'b1, 1'b1, 0, 1'b0, 1'b0);

        // Random operands.
        for (int i = 0; i < 8; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_add_ctrl
